packet_status_table: RTL and testbench

- Producer side of the circular buffer's `packet_status` / `reorder_tag_out` interface.
- Hands out reorder tags to arriving packets in order and records the accept/reject verdicts that the filter cores return, keyed by tag.
- Answers status lookups for the tag the circular buffer is currently draining.
- Returns each slot to PENDING once the circular buffer releases it.

---
 rtl/packet_status_table_pkg.sv | 25 ++
 rtl/packet_status_table_tag_ring_ptr.sv | 38 +++
 rtl/packet_status_table.sv | 146 ++++++++++++++
 tb/tb_packet_status_table.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_status_table_pkg.sv
// Shared definitions for the reorder-tag status table and the circular buffer that consumes it.
// Status encodings and the tag-pointer wrap helper live here so both sides stay in step.
package packet_status_table_pkg;

    localparam int DEF_TAG_WIDTH = 6;
    localparam int DEF_SIZE      = 3;

    typedef enum logic [1:0] {
        PENDING  = 2'b00,
        REJECTED = 2'b01,
        ACCEPTED = 2'b11
    } pkt_status_e;

    // Increment modulo size; size need not be a power of two.
    function automatic logic [31:0] wrap_inc(input logic [31:0] val, input logic [31:0] size);
        logic [31:0] nxt;
        if (val >= size - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = val + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/packet_status_table_tag_ring_ptr.sv
// Modulo-SIZE ring pointer with an advance enable; used for the allocation and head pointers.
module tag_ring_ptr
    import packet_status_table_pkg::*;
#(
    parameter int W    = DEF_TAG_WIDTH,
    parameter int SIZE = DEF_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value: wrap-advance when enabled, otherwise hold
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = W'(wrap_inc(32'(ptr_q), 32'(SIZE)));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/packet_status_table.sv
// Reorder-tag allocator and verdict table feeding the circular buffer's drain side.
// Tags are granted in order, verdicts are stored per tag, and slots return to PENDING on release.
module packet_status_table
    import packet_status_table_pkg::*;
#(
    parameter int TAG_WIDTH            = DEF_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEF_SIZE,
    localparam int OCC_W               = $clog2(CIRCULAR_BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    output logic                 table_full,
    input  logic                 verdict_valid,
    input  logic [TAG_WIDTH-1:0] verdict_tag,
    input  logic                 verdict_accept,
    input  logic [TAG_WIDTH-1:0] reorder_tag_out,
    output logic [1:0]           packet_status,
    input  logic                 release_valid,
    input  logic [TAG_WIDTH-1:0] release_tag,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 err
);

    localparam int SIZE = CIRCULAR_BUFFER_SIZE;

    pkt_status_e          status_q [SIZE];
    pkt_status_e          status_d [SIZE];
    logic [SIZE-1:0]      in_use_q;
    logic [SIZE-1:0]      in_use_d;
    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;
    logic                 err_q;
    logic                 err_d;

    logic [TAG_WIDTH-1:0] alloc_ptr_s;
    logic [TAG_WIDTH-1:0] head_ptr_s;
    logic                 grant_s;
    logic                 verdict_legal_s;
    logic                 release_legal_s;
    pkt_status_e          lookup_status_s;

    // Full is judged on registered occupancy, so a same-cycle release never frees a grant.
    assign table_full = (occ_q == OCC_W'(SIZE));
    assign grant_s    = alloc_req & ~table_full;

    tag_ring_ptr #(.W(TAG_WIDTH), .SIZE(SIZE)) u_alloc_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (grant_s),
        .ptr_o (alloc_ptr_s)
    );

    tag_ring_ptr #(.W(TAG_WIDTH), .SIZE(SIZE)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (release_legal_s),
        .ptr_o (head_ptr_s)
    );

    // Legality of verdict/release and the lookup read, all against pre-edge slot state
    always_comb begin
        verdict_legal_s = 1'b0;
        release_legal_s = 1'b0;
        lookup_status_s = PENDING;
        for (int i = 0; i < SIZE; i++) begin
            if (verdict_tag == TAG_WIDTH'(i)) begin
                verdict_legal_s = verdict_valid & in_use_q[i] & (status_q[i] == PENDING);
            end else begin
                verdict_legal_s = verdict_legal_s;
            end
            if (head_ptr_s == TAG_WIDTH'(i)) begin
                release_legal_s = release_valid & (release_tag == head_ptr_s)
                                & in_use_q[i] & (status_q[i] != PENDING);
            end else begin
                release_legal_s = release_legal_s;
            end
            if ((reorder_tag_out == TAG_WIDTH'(i)) && in_use_q[i]) begin
                lookup_status_s = status_q[i];
            end else begin
                lookup_status_s = lookup_status_s;
            end
        end
    end

    // Slot, occupancy and error next-state
    always_comb begin
        in_use_d = in_use_q;
        for (int i = 0; i < SIZE; i++) begin
            status_d[i] = status_q[i];
        end
        for (int i = 0; i < SIZE; i++) begin
            if (release_legal_s && (head_ptr_s == TAG_WIDTH'(i))) begin
                in_use_d[i] = 1'b0;
                status_d[i] = PENDING;
            end else begin
                in_use_d[i] = in_use_d[i];
            end
            if (grant_s && (alloc_ptr_s == TAG_WIDTH'(i))) begin
                in_use_d[i] = 1'b1;
                status_d[i] = PENDING;
            end else begin
                in_use_d[i] = in_use_d[i];
            end
            if (verdict_legal_s && (verdict_tag == TAG_WIDTH'(i))) begin
                status_d[i] = verdict_accept ? ACCEPTED : REJECTED;
            end else begin
                status_d[i] = status_d[i];
            end
        end
        err_d = err_q | (verdict_valid & ~verdict_legal_s) | (release_valid & ~release_legal_s);
        case ({grant_s, release_legal_s})
            2'b10:   occ_d = occ_q + OCC_W'(1'b1);
            2'b01:   occ_d = occ_q - OCC_W'(1'b1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset discards every slot and ignores same-cycle events
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                status_q[i] <= PENDING;
            end
            in_use_q <= {SIZE{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                status_q[i] <= status_d[i];
            end
            in_use_q <= in_use_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    assign alloc_grant   = grant_s;
    assign alloc_tag     = alloc_ptr_s;
    assign packet_status = lookup_status_s;
    assign occupancy     = occ_q;
    assign err           = err_q;

endmodule

// File: tb/tb_packet_status_table.sv
// Directed and scoreboard-driven bench for packet_status_table (3 slots, 6-bit tags).
module tb_packet_status_table;

    localparam int TW = 6;
    localparam int SZ = 3;
    localparam int OW = $clog2(SZ + 1);
    localparam logic [1:0] S_P = 2'b00;
    localparam logic [1:0] S_R = 2'b01;
    localparam logic [1:0] S_A = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_grant;
    logic [TW-1:0] alloc_tag;
    logic          table_full;
    logic          verdict_valid;
    logic [TW-1:0] verdict_tag;
    logic          verdict_accept;
    logic [TW-1:0] reorder_tag_out;
    logic [1:0]    packet_status;
    logic          release_valid;
    logic [TW-1:0] release_tag;
    logic [OW-1:0] occupancy;
    logic          err;

    packet_status_table #(.TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(SZ)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_grant     (alloc_grant),
        .alloc_tag       (alloc_tag),
        .table_full      (table_full),
        .verdict_valid   (verdict_valid),
        .verdict_tag     (verdict_tag),
        .verdict_accept  (verdict_accept),
        .reorder_tag_out (reorder_tag_out),
        .packet_status   (packet_status),
        .release_valid   (release_valid),
        .release_tag     (release_tag),
        .occupancy       (occupancy),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] m_status [SZ];
    logic       m_in_use [SZ];
    int         m_alloc;
    int         m_head;
    int         m_occ;
    logic       m_err;
    logic [1:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SZ; i++) begin
            m_status[i] = S_P;
            m_in_use[i] = 1'b0;
        end
        m_alloc = 0;
        m_head  = 0;
        m_occ   = 0;
        m_err   = 1'b0;
    endtask

    function automatic logic [1:0] model_lookup(input int t);
        logic [1:0] r;
        r = S_P;
        if (t < SZ) begin
            if (m_in_use[t]) r = m_status[t];
        end
        return r;
    endfunction

    // Apply one clock edge of the reference behaviour using the currently driven inputs.
    task automatic model_edge();
        bit g, vl, rl;
        int vt, rt;
        if (rst) begin
            model_reset();
            return;
        end
        vt = int'(verdict_tag);
        rt = int'(release_tag);
        g  = alloc_req && (m_occ != SZ);
        vl = 1'b0;
        rl = 1'b0;
        if (verdict_valid && vt < SZ) begin
            if (m_in_use[vt] && m_status[vt] == S_P) vl = 1'b1;
        end
        if (release_valid && rt == m_head) begin
            if (m_in_use[rt] && m_status[rt] != S_P) rl = 1'b1;
        end
        if (verdict_valid && !vl) m_err = 1'b1;
        if (release_valid && !rl) m_err = 1'b1;
        if (rl) begin
            m_in_use[m_head] = 1'b0;
            m_status[m_head] = S_P;
            m_head = (m_head == SZ - 1) ? 0 : m_head + 1;
        end
        if (g) begin
            m_in_use[m_alloc] = 1'b1;
            m_status[m_alloc] = S_P;
            m_alloc = (m_alloc == SZ - 1) ? 0 : m_alloc + 1;
        end
        if (vl) m_status[vt] = verdict_accept ? S_A : S_R;
        if (g && !rl) m_occ = m_occ + 1;
        if (rl && !g) m_occ = m_occ - 1;
    endtask

    task automatic drive(input logic req, input logic vv, input int vt, input logic va,
                         input int look, input logic rv, input int rt);
        alloc_req       = req;
        verdict_valid   = vv;
        verdict_tag     = TW'(vt);
        verdict_accept  = va;
        reorder_tag_out = TW'(look);
        release_valid   = rv;
        release_tag     = TW'(rt);
    endtask

    // One cycle: queue the expected lookup, check outputs mid-cycle, then advance the model.
    task automatic step();
        logic exp_g;
        sb_q.push_back(model_lookup(int'(reorder_tag_out)));
        @(negedge clk);
        exp_g = alloc_req && (m_occ != SZ);
        chk("alloc_grant", 32'(alloc_grant), 32'(exp_g));
        if (exp_g) chk("alloc_tag", 32'(alloc_tag), 32'(m_alloc));
        chk("table_full", 32'(table_full), 32'(m_occ == SZ));
        chk("occupancy", 32'(occupancy), 32'(m_occ));
        chk("err", 32'(err), 32'(m_err));
        chk("packet_status", 32'(packet_status), 32'(sb_q.pop_front()));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic scan();
        for (int t = 0; t < SZ; t++) begin
            drive(1'b0, 1'b0, 0, 1'b0, t, 1'b0, 0);
            step();
        end
    endtask

    int vorder [10] = '{1, 0, 2, 2, 1, 2, 1, 0, 1, 2};
    int granted;
    int released;
    int vi;
    int vt_s;
    logic rq, vv, rv;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state, then fill the table
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
            step();
        end
        chk("full_after3", 32'(table_full), 32'd1);
        chk("occ_after3", 32'(occupancy), 32'd3);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("no_grant_when_full", 32'(alloc_grant), 32'd0);
        step();

        // Verdicts: tag1 accept, tag0 reject
        drive(1'b0, 1'b1, 1, 1'b1, 1, 1'b0, 0); step();
        drive(1'b0, 1'b1, 0, 1'b0, 1, 1'b0, 0);
        #1 chk("tag1_accepted", 32'(packet_status), 32'(S_A));
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("tag0_rejected", 32'(packet_status), 32'(S_R));
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 0);
        #1 chk("tag2_pending", 32'(packet_status), 32'(S_P));
        step();

        // Illegal release (not head) and double verdict
        drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b1, 1); step();
        drive(1'b0, 1'b1, 1, 1'b0, 1, 1'b0, 0); step();
        scan();
        chk("err_sticky", 32'(err), 32'd1);

        // Legal release of head, then wrap-around grant
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("occ_after_release", 32'(occupancy), 32'd2);
        chk("not_full_after_release", 32'(table_full), 32'd0);
        chk("released_reads_pending", 32'(packet_status), 32'(S_P));
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("wrap_tag", 32'(alloc_tag), 32'd0);
        step();

        // Full table: release head and request together
        drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b1, 1);
        #1 chk("no_grant_full_release", 32'(alloc_grant), 32'd0);
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 0);
        #1 chk("grant_after_release", 32'(alloc_grant), 32'd1);
        step();
        chk("occ_back_to_3", 32'(occupancy), 32'd3);

        // Release of a PENDING head, then verdict + release on the same tag
        drive(1'b0, 1'b0, 0, 1'b0, 2, 1'b1, 2); step();
        drive(1'b0, 1'b1, 2, 1'b1, 2, 1'b1, 2); step();
        drive(1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 0);
        #1 chk("verdict_wrote_despite_release", 32'(packet_status), 32'(S_A));
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 2, 1'b1, 2); step();
        scan();

        // Reset mid-operation with active inputs
        rst = 1'b1;
        drive(1'b1, 1'b1, 0, 1'b1, 0, 1'b1, 0); step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("err_cleared_by_rst", 32'(err), 32'd0);
        chk("occ_cleared_by_rst", 32'(occupancy), 32'd0);
        step();

        // Grant and verdict to the same slot in one cycle
        drive(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 chk("grant_verdict_same_slot_err", 32'(err), 32'd1);
        chk("grant_verdict_slot_pending", 32'(packet_status), 32'(S_P));
        step();

        // Out-of-range verdict after a fresh reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0); step();
        rst = 1'b0;
        drive(1'b0, 1'b1, 5, 1'b1, 5, 1'b0, 0); step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0); step();
        rst = 1'b0;

        // Ten packets, out-of-order verdicts, in-order release
        granted  = 0;
        released = 0;
        vi       = 0;
        for (int c = 0; c < 300 && released < 10; c++) begin
            rq = (granted < 10) && (m_occ < SZ);
            vt_s = vorder[vi % 10];
            vi++;
            vv = m_in_use[vt_s] && (m_status[vt_s] == S_P);
            rv = m_in_use[m_head] && (m_status[m_head] != S_P);
            drive(rq, vv, vt_s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                  rv, m_head);
            if (rq) granted++;
            if (rv) released++;
            step();
        end
        chk("random_all_released", 32'(released), 32'd10);
        chk("random_final_occ", 32'(occupancy), 32'd0);
        chk("random_no_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
